// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: state encoding, reset PC, NOP and
// the opcode values that the decoder also relies on.
package fetch_pkg;

   typedef enum logic {
      REQ  = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID slot register: flush beats load, load beats consume, otherwise hold.
module ifid_reg
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned INSTR_WIDTH = 32
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   load,
   input  logic                   consume,
   input  logic [INSTR_WIDTH-1:0] instr_in,
   input  logic [ADDR_WIDTH-1:0]  pc_in,
   input  logic [ADDR_WIDTH-1:0]  pc_plus4_in,
   output logic                   valid,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0]  pc,
   output logic [ADDR_WIDTH-1:0]  pc_plus4
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         instr    <= INSTR_WIDTH'(NOP_INSTR);
         pc       <= '0;
         pc_plus4 <= ADDR_WIDTH'(4);
      end else if (flush) begin
         // pc fields keep their last value; only the instruction becomes a bubble
         valid <= 1'b0;
         instr <= INSTR_WIDTH'(NOP_INSTR);
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= instr_in;
         pc       <= pc_in;
         pc_plus4 <= pc_plus4_in;
      end else if (consume) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read, IF/ID slot with decode
// back-pressure, and redirect handling that drops any in-flight response.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
)(
   input  logic                   clk,
   input  logic                   rst_n,
   output logic                   imem_req,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   input  logic                   imem_rvalid,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   input  logic                   id_stall,
   output logic                   if_valid,
   output logic [INSTR_WIDTH-1:0] if_instr,
   output logic [ADDR_WIDTH-1:0]  if_pc,
   output logic [ADDR_WIDTH-1:0]  if_pc_plus4
);

   fetch_state_t          state, state_next;
   logic [ADDR_WIDTH-1:0] pc, pc_next, pc_plus4, redirect_target;
   logic                  drop, drop_next;
   logic                  free, consume, load;

   assign pc_plus4        = pc + ADDR_WIDTH'(4);
   assign redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
   assign free            = !if_valid || !id_stall;
   assign consume         = if_valid && !id_stall;
   assign imem_addr       = pc;

   always_comb begin
      state_next = state;
      pc_next    = pc;
      drop_next  = drop;
      imem_req   = 1'b0;
      load       = 1'b0;
      case (state)
         REQ: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
            end else if (free && rst_n) begin
               // a request is only issued when the slot will be free to take its data
               imem_req   = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               pc_next = redirect_target;
               if (imem_rvalid) begin
                  drop_next  = 1'b0;
                  state_next = REQ;
               end else begin
                  drop_next = 1'b1;
               end
            end else if (imem_rvalid) begin
               state_next = REQ;
               if (drop) begin
                  drop_next = 1'b0;
               end else begin
                  load    = 1'b1;
                  pc_next = pc_plus4;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= REQ;
         pc    <= RESET_PC;
         drop  <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         drop  <= drop_next;
      end
   end

   ifid_reg #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_ifid (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (redirect_valid),
      .load        (load),
      .consume     (consume),
      .instr_in    (imem_rdata),
      .pc_in       (pc),
      .pc_plus4_in (pc_plus4),
      .valid       (if_valid),
      .instr       (if_instr),
      .pc          (if_pc),
      .pc_plus4    (if_pc_plus4)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stream and the IF/ID slot.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_rvalid = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_stall = 1'b0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;

   fetch_stage #(
      .ADDR_WIDTH  (32),
      .INSTR_WIDTH (32),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_rvalid    (imem_rvalid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: expected slot contents, next fetch address, outstanding read
   bit          m_valid;
   logic [31:0] m_instr, m_pc, m_p4;
   logic [31:0] fetch_pc;
   bit          pend, pend_stale;
   logic [31:0] pend_addr;
   int          pend_due;
   int          cyc = 0;
   int          lat = 1;

   // values seen in the most recent cycle
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_instr, s_pc, s_p4;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      rst_n          = 1'b0;
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      id_stall       = 1'b0;
      #1;
      chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
      chk("rst_if_instr", if_instr, NOP);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_pc_plus4", if_pc_plus4, 32'h4);
      chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
      m_valid  = 1'b0;
      m_instr  = NOP;
      m_pc     = 32'h0;
      m_p4     = 32'h4;
      fetch_pc = 32'h0;
      pend     = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic step(input bit stall, input bit redir, input logic [31:0] rpc, input bit spur);
      bit delivered, exp_req, captured;
      @(negedge clk);
      id_stall       = stall;
      redirect_valid = redir;
      redirect_pc    = rpc;
      delivered      = pend && (pend_due == cyc);
      if (delivered) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend_addr);
      end else if (spur && !pend) begin
         imem_rvalid = 1'b1;
         imem_rdata  = $urandom;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      s_req = imem_req;  s_addr = imem_addr;  s_valid = if_valid;
      s_instr = if_instr;  s_pc = if_pc;  s_p4 = if_pc_plus4;

      chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_pc);
      chk("if_pc_plus4", if_pc_plus4, m_p4);
      exp_req = !pend && (!m_valid || !stall) && !redir;
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, fetch_pc);

      captured = 1'b0;
      if (delivered) begin
         pend = 1'b0;
         if (!pend_stale && !redir) captured = 1'b1;
      end else if (redir && pend) begin
         pend_stale = 1'b1;
      end
      if (redir) begin
         m_valid  = 1'b0;
         m_instr  = NOP;
         fetch_pc = rpc & 32'hFFFF_FFFC;
      end else if (captured) begin
         m_valid  = 1'b1;
         m_instr  = mem_word(pend_addr);
         m_pc     = pend_addr;
         m_p4     = pend_addr + 32'd4;
         fetch_pc = pend_addr + 32'd4;
      end else if (m_valid && !stall) begin
         m_valid = 1'b0;
      end
      if (exp_req) begin
         pend       = 1'b1;
         pend_stale = 1'b0;
         pend_addr  = fetch_pc;
         pend_due   = cyc + lat;
      end
      cyc++;
   endtask

   logic [31:0] held_instr;
   logic [31:0] tgt;

   initial begin
      // basic fetch with a 1-cycle memory
      reset_dut();
      lat = 1;
      step(0, 0, 0, 0);
      chk("p1_req_c0", {31'b0, s_req}, 32'd1);
      chk("p1_addr_c0", s_addr, 32'h0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("p1_valid_c2", {31'b0, s_valid}, 32'd1);
      chk("p1_instr_c2", s_instr, 32'h0050_0093);
      chk("p1_pc_c2", s_pc, 32'h0);
      chk("p1_addr_c2", s_addr, 32'h4);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("p1_valid_c4", {31'b0, s_valid}, 32'd1);
      chk("p1_instr_c4", s_instr, 32'h0010_0113);
      chk("p1_pc_c4", s_pc, 32'h4);

      // decode stall holds the slot and blocks requests
      reset_dut();
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      held_instr = s_instr;
      for (int i = 0; i < 4; i++) begin
         step(1, 0, 0, 0);
         chk("p2_no_req", {31'b0, s_req}, 32'd0);
      end
      chk("p2_instr_held", s_instr, held_instr);
      step(0, 0, 0, 0);
      chk("p2_req_after", {31'b0, s_req}, 32'd1);
      chk("p2_addr_after", s_addr, 32'h4);

      // redirect while waiting; stale response dropped
      reset_dut();
      lat = 4;
      step(0, 0, 0, 0);
      step(0, 1, 32'h40, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("p3_valid_after_drop", {31'b0, if_valid}, 32'd0);
      lat = 1;
      step(0, 0, 0, 0);
      chk("p3_addr_redir", s_addr, 32'h40);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("p3_valid", {31'b0, s_valid}, 32'd1);
      chk("p3_if_pc", s_pc, 32'h40);

      // redirect coinciding with a response, and redirect beating a stall
      reset_dut();
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 1, 32'h80, 0);
      step(1, 0, 0, 0);
      chk("p4_valid_flushed", {31'b0, s_valid}, 32'd0);
      chk("p4_instr_nop", s_instr, NOP);
      chk("p4_addr_redir", s_addr, 32'h80);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("p4_pc_80", s_pc, 32'h80);
      step(1, 1, 32'h100, 0);
      step(0, 0, 0, 0);
      chk("p4_stall_flush", {31'b0, s_valid}, 32'd0);
      chk("p4_addr_100", s_addr, 32'h100);

      // misaligned target near the top of the address space, pc wrap
      reset_dut();
      step(0, 1, 32'hFFFF_FFFE, 0);
      chk("p5_no_req", {31'b0, s_req}, 32'd0);
      step(0, 0, 0, 0);
      chk("p5_addr_top", s_addr, 32'hFFFF_FFFC);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("p5_pc_plus4_wrap", s_p4, 32'h0);
      chk("p5_addr_wrap", s_addr, 32'h0);

      // reset in the middle of a fetch, then a stale response
      reset_dut();
      lat = 3;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      reset_dut();
      step(0, 0, 0, 1);
      chk("p6_req_restart", {31'b0, s_req}, 32'd1);
      chk("p6_addr_restart", s_addr, 32'h0);
      step(0, 0, 0, 0);
      chk("p6_valid_stays0", {31'b0, s_valid}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(199) == 0) reset_dut();
         lat = $urandom_range(1, 3);
         case ($urandom_range(2))
            0:       tgt = $urandom;
            1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            default: tgt = 32'($urandom_range(255));
         endcase
         step($urandom_range(99) < 30, $urandom_range(99) < 10, tgt, $urandom_range(99) < 10);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
